// File: rtl/bus_rr_router.sv
// Shared-bus router: per-driver input/output FIFOs, round-robin grant of one packet per cycle,
// unicast/broadcast routing by ID field. Define BUS_DROP_CNT_EN to add the saturating drop_cnt port.
module bus_rr_router #(
    parameter int unsigned     WIDTH     = 16,
    parameter int unsigned     DEPTH     = 8,
    parameter int unsigned     DRVRS     = 4,
    parameter int unsigned     ID_W      = 8,
    parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DRVRS-1:0]       push,
    input  logic [DRVRS*WIDTH-1:0] D_push,
    output logic [DRVRS-1:0]       full,
    input  logic [DRVRS-1:0]       pop,
    output logic [DRVRS*WIDTH-1:0] D_pop,
    output logic [DRVRS-1:0]       pndng
`ifdef BUS_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = $clog2(DRVRS);

    logic [WIDTH-1:0] in_mem  [DRVRS][DEPTH];
    logic [WIDTH-1:0] out_mem [DRVRS][DEPTH];
    logic [AW-1:0]    in_wp  [DRVRS];
    logic [AW-1:0]    in_rp  [DRVRS];
    logic [AW-1:0]    out_wp [DRVRS];
    logic [AW-1:0]    out_rp [DRVRS];
    logic [CW-1:0]    in_cnt [DRVRS];
    logic [CW-1:0]    out_cnt[DRVRS];
    logic [PW-1:0]    ptr;

    logic [DRVRS-1:0] in_full, in_empty, out_full, out_empty;
    logic [DRVRS-1:0] deliverable, invalid, eligible, gnt_oh, in_acc, out_wr, out_rd;
    logic [WIDTH-1:0] head    [DRVRS];
    logic [ID_W-1:0]  head_id [DRVRS];
    logic             grant_vld, g_inv;
    logic [PW-1:0]    grant;
    logic [WIDTH-1:0] g_pkt;
    logic [ID_W-1:0]  g_id;
    int unsigned      rel, best;

    // FIFO status and input heads
    always_comb begin
        in_full   = '0;
        in_empty  = '0;
        out_full  = '0;
        out_empty = '0;
        for (int i = 0; i < DRVRS; i++) begin
            in_full[i]   = (in_cnt[i] == CW'(DEPTH));
            in_empty[i]  = (in_cnt[i] == '0);
            out_full[i]  = (out_cnt[i] == CW'(DEPTH));
            out_empty[i] = (out_cnt[i] == '0);
            head[i]      = in_mem[i][in_rp[i]];
            head_id[i]   = head[i][WIDTH-1 -: ID_W];
        end
    end

    // Eligibility: invalid/self IDs are always eligible so they can be flushed
    always_comb begin
        deliverable = '1;
        invalid     = '0;
        eligible    = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (head_id[i] == BROADCAST) begin
                for (int j = 0; j < DRVRS; j++)
                    if (j != i && out_full[j]) deliverable[i] = 1'b0;
            end else if (head_id[i] < ID_W'(DRVRS) && head_id[i] != ID_W'(i)) begin
                for (int j = 0; j < DRVRS; j++)
                    if (head_id[i] == ID_W'(j) && out_full[j]) deliverable[i] = 1'b0;
            end else begin
                invalid[i] = 1'b1;
            end
            eligible[i] = !in_empty[i] && (deliverable[i] || invalid[i]);
        end
    end

    // Round-robin: eligible driver with the smallest distance from ptr wins
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        gnt_oh    = '0;
        g_pkt     = '0;
        g_inv     = 1'b0;
        best      = DRVRS;
        rel       = 0;
        for (int unsigned i = 0; i < DRVRS; i++) begin
            rel = (i + DRVRS - 32'(ptr)) % DRVRS;
            if (eligible[i] && rel < best) begin
                best      = rel;
                grant_vld = 1'b1;
                grant     = PW'(i);
                gnt_oh    = '0;
                gnt_oh[i] = 1'b1;
                g_pkt     = head[i];
                g_inv     = invalid[i];
            end
        end
    end

    assign g_id = g_pkt[WIDTH-1 -: ID_W];

    always_comb begin
        out_wr = '0;
        for (int j = 0; j < DRVRS; j++) begin
            if (grant_vld && !g_inv) begin
                if (g_id == BROADCAST) out_wr[j] = !gnt_oh[j];
                else                   out_wr[j] = (g_id == ID_W'(j));
            end
        end
    end

    // A push into a full FIFO is still taken when the same edge pops its head
    assign in_acc = push & (~in_full | gnt_oh);
    assign out_rd = pop & ~out_empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DRVRS; i++) begin
                in_wp[i]   <= '0;
                in_rp[i]   <= '0;
                in_cnt[i]  <= '0;
                out_wp[i]  <= '0;
                out_rp[i]  <= '0;
                out_cnt[i] <= '0;
            end
            ptr <= '0;
        end else begin
            for (int i = 0; i < DRVRS; i++) begin
                if (in_acc[i]) in_wp[i] <= in_wp[i] + AW'(1);
                if (gnt_oh[i]) in_rp[i] <= in_rp[i] + AW'(1);
                in_cnt[i] <= in_cnt[i] + CW'(in_acc[i]) - CW'(gnt_oh[i]);
                if (out_wr[i]) out_wp[i] <= out_wp[i] + AW'(1);
                if (out_rd[i]) out_rp[i] <= out_rp[i] + AW'(1);
                out_cnt[i] <= out_cnt[i] + CW'(out_wr[i]) - CW'(out_rd[i]);
            end
            if (grant_vld) ptr <= (grant == PW'(DRVRS - 1)) ? '0 : grant + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DRVRS; i++) begin
            if (in_acc[i]) in_mem[i][in_wp[i]] <= D_push[i*WIDTH +: WIDTH];
            if (out_wr[i]) out_mem[i][out_wp[i]] <= g_pkt;
        end
    end

    always_comb begin
        full  = in_full;
        pndng = ~out_empty;
        D_pop = '0;
        for (int j = 0; j < DRVRS; j++)
            if (!out_empty[j]) D_pop[j*WIDTH +: WIDTH] = out_mem[j][out_rp[j]];
    end

`ifdef BUS_DROP_CNT_EN
    localparam int unsigned DW = $clog2(DRVRS + 2);
    logic [DW-1:0] drop_inc;
    logic [16:0]   drop_sum;

    // Rejected pushes plus a flushed invalid head, summed per cycle
    always_comb begin
        drop_inc = DW'(grant_vld && g_inv);
        for (int i = 0; i < DRVRS; i++)
            drop_inc = drop_inc + DW'(push[i] && in_full[i] && !gnt_oh[i]);
        drop_sum = {1'b0, drop_cnt} + 17'(drop_inc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) drop_cnt <= '0;
        else       drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif
endmodule

// File: tb/tb_bus_rr_router.sv
// Bench for bus_rr_router: directed scenarios plus randomized traffic against a queue-based model.
module tb_bus_rr_router;
    logic        clk, reset;
    logic [3:0]  push, pop, full, pndng;
    logic [63:0] D_push, D_pop;
`ifdef BUS_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif
    int checks, errors;

    // Reference model: packet queues per FIFO, rotating priority index
    logic [15:0] mq_in  [4][$];
    logic [15:0] mq_out [4][$];
    int mptr, mdrops;

    bus_rr_router #(.WIDTH(16), .DEPTH(8), .DRVRS(4), .ID_W(8)) dut (
        .clk(clk), .reset(reset), .push(push), .D_push(D_push), .full(full),
        .pop(pop), .D_pop(D_pop), .pndng(pndng)
`ifdef BUS_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] dpop(input int j);
        return D_pop[j*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pkt(input int i, input logic [15:0] v);
        D_push[i*16 +: 16] = v;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mq_in[i].delete();
            mq_out[i].delete();
        end
        mptr   = 0;
        mdrops = 0;
    endtask

    task automatic apply_reset(input int n);
        reset  = 1'b1;
        push   = '0;
        pop    = '0;
        D_push = '0;
        repeat (n) tick();
        reset = 1'b0;
        model_reset();
    endtask

    // One clock edge of the bus, decided from the state before the edge
    task automatic model_step(input logic [3:0] p, input logic [63:0] d, input logic [3:0] pp);
        int in_sz [4];
        int out_sz [4];
        int g, src;
        logic [15:0] pkt;
        logic [7:0] id;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            in_sz[i]  = mq_in[i].size();
            out_sz[i] = mq_out[i].size();
        end
        g = -1;
        for (int k = 0; k < 4; k++) begin
            src = (mptr + k) % 4;
            if (g < 0 && in_sz[src] > 0) begin
                pkt = mq_in[src][0];
                id  = pkt[15:8];
                if (id == 8'hFF) begin
                    ok = 1'b1;
                    for (int j = 0; j < 4; j++) if (j != src && out_sz[j] >= 8) ok = 1'b0;
                end else if (id < 4 && int'(id) != src) begin
                    ok = (out_sz[id] < 8);
                end else begin
                    ok = 1'b1;
                end
                if (ok) g = src;
            end
        end
        if (g >= 0) begin
            pkt  = mq_in[g].pop_front();
            id   = pkt[15:8];
            mptr = (g + 1) % 4;
            if (id == 8'hFF) begin
                for (int j = 0; j < 4; j++) if (j != g) mq_out[j].push_back(pkt);
            end else if (id < 4 && int'(id) != g) begin
                mq_out[id].push_back(pkt);
            end else begin
                mdrops++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (p[i]) begin
                if (in_sz[i] < 8 || g == i) mq_in[i].push_back(d[i*16 +: 16]);
                else mdrops++;
            end
        end
        for (int j = 0; j < 4; j++)
            if (pp[j] && out_sz[j] > 0) void'(mq_out[j].pop_front());
    endtask

    task automatic test_reset();
        reset = 1'b1; push = '0; pop = '0; D_push = '0;
        tick();
        checks++; if (full !== 4'b0) begin errors++; $display("FAIL rst_full got %b exp 0000", full); end
        checks++; if (pndng !== 4'b0) begin errors++; $display("FAIL rst_pndng got %b exp 0000", pndng); end
        checks++; if (D_pop !== 64'h0) begin errors++; $display("FAIL rst_dpop got %h exp 0", D_pop); end
        tick();
        reset = 1'b0;
        tick();
`ifdef BUS_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_cnt); end
`endif
    endtask

    task automatic test_unicast();
        push = 4'b0001; set_pkt(0, 16'h02AB);
        tick();
        push = '0;
        checks++; if (pndng !== 4'b0000) begin errors++; $display("FAIL uni_latency got %b exp 0000", pndng); end
        tick();
        checks++; if (pndng !== 4'b0100) begin errors++; $display("FAIL uni_pndng got %b exp 0100", pndng); end
        checks++; if (dpop(2) !== 16'h02AB) begin errors++; $display("FAIL uni_data got %h exp 02ab", dpop(2)); end
        pop = 4'b0100;
        tick();
        pop = '0;
        checks++; if (pndng !== 4'b0000) begin errors++; $display("FAIL uni_pop got %b exp 0000", pndng); end
        checks++; if (dpop(2) !== 16'h0) begin errors++; $display("FAIL uni_pop_data got %h exp 0000", dpop(2)); end
    endtask

    task automatic test_broadcast();
        push = 4'b0010; set_pkt(1, 16'hFF5A);
        tick();
        push = '0;
        tick();
        checks++; if (pndng !== 4'b1101) begin errors++; $display("FAIL bc_pndng got %b exp 1101", pndng); end
        for (int j = 0; j < 4; j++) begin
            if (j != 1) begin
                checks++;
                if (dpop(j) !== 16'hFF5A) begin errors++; $display("FAIL bc_data%0d got %h exp ff5a", j, dpop(j)); end
            end
        end
        pop = 4'b1101;
        tick();
        pop = '0;
        checks++; if (pndng !== 4'b0000) begin errors++; $display("FAIL bc_drain got %b exp 0000", pndng); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_p;
        logic [7:0] tag;
        apply_reset(2);
        for (int r = 0; r < 2; r++) begin
            tag  = (r == 0) ? 8'h40 : 8'h80;
            push = 4'b1111;
            for (int i = 0; i < 4; i++) set_pkt(i, {8'((i + 1) % 4), 8'(tag + 8'(i))});
            tick();
            push  = '0;
            exp_p = '0;
            for (int k = 0; k < 4; k++) begin
                tick();
                exp_p[(k + 1) % 4] = 1'b1;
                checks++;
                if (pndng !== exp_p) begin errors++; $display("FAIL rr%0d_step%0d got %b exp %b", r, k, pndng, exp_p); end
            end
            for (int d = 0; d < 4; d++) begin
                checks++;
                if (dpop(d) !== {8'(d), 8'(tag + 8'((d + 3) % 4))})
                    begin errors++; $display("FAIL rr%0d_data%0d got %h exp %h", r, d, dpop(d), {8'(d), 8'(tag + 8'((d + 3) % 4))}); end
            end
            pop = 4'b1111;
            tick();
            pop = '0;
        end
    endtask

    task automatic test_backpressure();
        apply_reset(2);
        for (int k = 1; k <= 17; k++) begin
            push = 4'b0001; set_pkt(0, {8'h03, 8'(k)});
            tick();
        end
        push = '0;
        checks++; if (full !== 4'b0001) begin errors++; $display("FAIL bp_full got %b exp 0001", full); end
        checks++; if (dpop(3) !== 16'h0301) begin errors++; $display("FAIL bp_head got %h exp 0301", dpop(3)); end
`ifdef BUS_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL bp_drop got %0d exp 1", drop_cnt); end
`endif
        push = 4'b0010; set_pkt(1, 16'h02C1);
        tick();
        push = '0;
        tick();
        checks++; if (pndng !== 4'b1100) begin errors++; $display("FAIL bp_other_pndng got %b exp 1100", pndng); end
        checks++; if (dpop(2) !== 16'h02C1) begin errors++; $display("FAIL bp_other_data got %h exp 02c1", dpop(2)); end
        pop = 4'b1000;
        tick();
        pop = '0;
        checks++; if (dpop(3) !== 16'h0302) begin errors++; $display("FAIL bp_pop_head got %h exp 0302", dpop(3)); end
        checks++; if (full[0] !== 1'b1) begin errors++; $display("FAIL bp_full_prepop got %b exp 1", full[0]); end
        tick();
        checks++; if (full[0] !== 1'b0) begin errors++; $display("FAIL bp_one_moved got %b exp 0", full[0]); end
        push = 4'b0001; set_pkt(0, 16'h0312);
        tick();
        push = '0;
        checks++; if (full[0] !== 1'b1) begin errors++; $display("FAIL bp_only_one got %b exp 1", full[0]); end
    endtask

    task automatic test_invalid();
        apply_reset(2);
        push = 4'b0100; set_pkt(2, 16'h0211);
        tick();
        set_pkt(2, 16'h0733);
        tick();
        push = '0;
        repeat (3) tick();
        checks++; if (pndng !== 4'b0000) begin errors++; $display("FAIL inv_pndng got %b exp 0000", pndng); end
        checks++; if (full !== 4'b0000) begin errors++; $display("FAIL inv_full got %b exp 0000", full); end
`ifdef BUS_DROP_CNT_EN
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL inv_drop got %0d exp 2", drop_cnt); end
`endif
    endtask

    task automatic test_mid_reset();
        apply_reset(2);
        for (int k = 0; k < 4; k++) begin
            push = 4'b0101;
            set_pkt(0, {8'h01, 8'(k)});
            set_pkt(2, {8'h03, 8'(k + 16)});
            tick();
        end
        push = '0;
        checks++; if (pndng !== 4'b1010) begin errors++; $display("FAIL mr_pre got %b exp 1010", pndng); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (full !== 4'b0) begin errors++; $display("FAIL mr_full got %b exp 0000", full); end
        checks++; if (pndng !== 4'b0) begin errors++; $display("FAIL mr_pndng got %b exp 0000", pndng); end
        checks++; if (D_pop !== 64'h0) begin errors++; $display("FAIL mr_dpop got %h exp 0", D_pop); end
        repeat (3) tick();
        reset = 1'b0;
        push = 4'b1001; set_pkt(0, 16'h01AA); set_pkt(3, 16'h02BB);
        tick();
        push = '0;
        tick();
        checks++; if (pndng !== 4'b0010) begin errors++; $display("FAIL mr_first got %b exp 0010", pndng); end
        checks++; if (dpop(1) !== 16'h01AA) begin errors++; $display("FAIL mr_data got %h exp 01aa", dpop(1)); end
        tick();
        checks++; if (pndng !== 4'b0110) begin errors++; $display("FAIL mr_second got %b exp 0110", pndng); end
    endtask

    task automatic test_random();
        logic [3:0]  pv, pp, exp_full, exp_pndng;
        logic [63:0] dv, exp_dpop;
        logic [7:0]  id;
        int push_pct, pop_pct, r;
        apply_reset(2);
        for (int c = 0; c < 800; c++) begin
            push_pct = (c < 400) ? 55 : 25;
            pop_pct  = (c < 400) ? 20 : 75;
            dv = '0;
            for (int i = 0; i < 4; i++) begin
                pv[i] = ($urandom_range(0, 99) < push_pct);
                pp[i] = ($urandom_range(0, 99) < pop_pct);
                r = int'($urandom_range(0, 9));
                if (r < 6)       id = 8'($urandom_range(0, 3));
                else if (r < 8)  id = 8'hFF;
                else if (r == 8) id = 8'($urandom_range(4, 254));
                else             id = 8'(i);
                dv[i*16 +: 16] = {id, 8'($urandom)};
            end
            push = pv; D_push = dv; pop = pp;
            model_step(pv, dv, pp);
            tick();
            exp_full = '0; exp_pndng = '0; exp_dpop = '0;
            for (int j = 0; j < 4; j++) begin
                exp_full[j] = (mq_in[j].size() == 8);
                if (mq_out[j].size() > 0) begin
                    exp_pndng[j] = 1'b1;
                    exp_dpop[j*16 +: 16] = mq_out[j][0];
                end
            end
            checks++; if (full !== exp_full) begin errors++; $display("FAIL rnd_full c=%0d got %b exp %b", c, full, exp_full); end
            checks++; if (pndng !== exp_pndng) begin errors++; $display("FAIL rnd_pndng c=%0d got %b exp %b", c, pndng, exp_pndng); end
            checks++; if (D_pop !== exp_dpop) begin errors++; $display("FAIL rnd_dpop c=%0d got %h exp %h", c, D_pop, exp_dpop); end
`ifdef BUS_DROP_CNT_EN
            checks++; if (drop_cnt !== 16'(mdrops)) begin errors++; $display("FAIL rnd_drop c=%0d got %0d exp %0d", c, drop_cnt, mdrops); end
`endif
        end
        push = '0;
        pop  = '0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        test_reset();
        test_unicast();
        test_broadcast();
        test_round_robin();
        test_backpressure();
        test_invalid();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_rr_router.md
Name: bus_rr_router

Overview:
- Synthesizable N-driver shared data bus.
- Each driver port has an input FIFO and an output FIFO.
- A round-robin arbiter grants one packet per cycle onto the bus and routes it by its destination ID field to one output FIFO, or to all others on broadcast.
- Parametrised successor of the fixed 16-bit/depth-8/4-driver bus: width, depth, driver count and ID field are all generic. Adds broadcast, per-target backpressure and drop handling.

Parameters:
WIDTH, 16, packet width in bits; packet = {ID[ID_W-1:0], payload[WIDTH-ID_W-1:0]}
DEPTH, 8, entries per input FIFO and per output FIFO (power of two, >=2)
DRVRS, 4, number of driver ports (2..16)
ID_W, 8, destination ID field width (ID_W < WIDTH, 2**ID_W > DRVRS)
BROADCAST, {ID_W{1'b1}}, ID value meaning "all drivers except source"

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
push  in  DRVRS  per-driver write strobe into its input FIFO
D_push  in  DRVRS*WIDTH  per-driver packet, driver i at bits [i*WIDTH +: WIDTH]
full  out  DRVRS  per-driver input FIFO full
pop  in  DRVRS  per-driver read strobe from its output FIFO
D_pop  out  DRVRS*WIDTH  per-driver head of output FIFO (first-word fall-through)
pndng  out  DRVRS  per-driver output FIFO non-empty

Behaviour:
- Reset (async, any time, including mid-transfer):
  - All FIFOs empty, so full=0, pndng=0, D_pop=0.
  - Arbiter pointer=0; in-flight grant discarded.
- Input FIFO i, write path:
  - push[i] at edge t writes D_push slice.
  - push on full is ignored, unless the same edge pops FIFO i via a grant; then it is accepted.
- Head eligibility: head of input FIFO i is eligible when non-empty and deliverable:
  - Unicast ID d < DRVRS, d != i: deliverable when out FIFO d is not full.
  - BROADCAST: deliverable when every out FIFO j != i is not full.
  - Full is evaluated pre-edge; a same-cycle pop does not free space.
- Invalid head (ID >= DRVRS and != BROADCAST, or ID == source i):
  - Always eligible.
  - On grant it is removed and written nowhere (drop).
- Round-robin arbiter:
  - One grant per cycle among eligible heads.
  - Search starts at ptr; after granting g, ptr <= (g+1) mod DRVRS.
  - No eligible head: no grant, ptr holds.
  - A blocked head never blocks other drivers.
- Transfer: the granted head is popped and written into its target output FIFO(s) at the same edge. The whole packet, ID included, is stored unmodified.
- Latency: packet pushed at edge t into an idle bus appears on D_pop/pndng after edge t+1.
- Output FIFO j:
  - pop[j] at an edge removes the head; D_pop updates to the next entry, or to 0 when empty.
  - pop on empty is ignored.
  - Simultaneous write and pop on the same FIFO are both performed.
- Ordering: packets from one source to one destination arrive in push order.
- Pointers wrap modulo DEPTH. Occupancy counters are $clog2(DEPTH)+1 bits wide, so full is distinguishable from empty.

Optional Feature:
BUS_DROP_CNT_EN:
- Defined: adds output port drop_cnt (out, 16 bits, reset 0).
  - Increments by 1 for each ignored push-on-full and for each granted invalid head.
  - Two drop events in one cycle add 2.
  - Saturates at 16'hFFFF.
- Undefined: port absent; drops are silent, with no other behavioural change.

Test Plan:
- Unicast: after reset, driver 0 pushes 16'h02AB → pndng[2]=1 with D_pop[2]=16'h02AB after the next edge; every other pndng stays 0.
- Broadcast: driver 1 pushes 16'hFF5A → out FIFOs 0, 2 and 3 each hold 16'hFF5A one edge later; pndng[1]=0.
- Round-robin:
  - All 4 drivers push a valid packet to a distinct free destination at the same edge.
  - Grants follow the order 0,1,2,3 on consecutive cycles.
  - A second round after grant 3 starts at driver 0.
- Backpressure and overflow:
  - Fill out FIFO 3 with 8 packets and never pop it; driver 0 then pushes 9 more packets to ID 3.
  - Input FIFO 0 fills: full[0]=1 and the 9th push is dropped (drop_cnt=1 under macro).
  - Meanwhile driver 1 → ID 2 still delivers.
  - After one pop[3], exactly one packet moves.
- Invalid and self IDs: driver 2 pushes 16'h0211 and 16'h0733 → neither packet is delivered; drop_cnt=2 under macro.
- Mid-operation reset: assert reset for 3 cycles while FIFOs are half full and a grant is pending → full=0, pndng=0, D_pop=0 immediately. The next push from driver 0 to ID 1 is granted first.
